// File: rtl/event_pkg.sv
// Shared constants and packet helper for the event packetizer.
package event_pkg;
  localparam logic [1:0] EVT_NONE = 2'b00;
  localparam logic [1:0] EVT_A    = 2'b01;
  localparam logic [1:0] EVT_B    = 2'b10;
  localparam logic [1:0] EVT_AB   = 2'b11;

  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 6;
  localparam int UNIT_W   = 6;
  localparam int DROP_W   = 8;
  localparam int PKT_W    = 8;

  function automatic logic [PKT_W-1:0] make_pkt(input logic [1:0] code, input logic [UNIT_W-1:0] unit);
    return {code, unit};
  endfunction
endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with occupancy output; push while full is allowed when popping.
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  always_comb begin
    pop_ok_s  = pop && (level_q != {(AW+1){1'b0}});
    push_ok_s = push && ((level_q != (AW+1)'(DEPTH)) || pop_ok_s);
    wr_ptr_d  = push_ok_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (level_q != {(AW+1){1'b0}});
  assign full       = (level_q == (AW+1)'(DEPTH));
  assign level      = level_q;
endmodule

// File: rtl/event_packetizer.sv
// Latches per-unit event codes into pending slots and serialises them round-robin into 8-bit packets.
module event_packetizer
  import event_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*NUM_UNITS-1:0]        event_in_array,
  output logic [PKT_W-1:0]              pkt_data,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [DROP_W-1:0]             drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] pend_q, pend_d;
  logic [1:0]           code_q [NUM_UNITS];
  logic [1:0]           code_d [NUM_UNITS];
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic [PW-1:0]        gnt_idx_s;
  logic                 gnt_found_s, gnt_s, pop_s, fifo_full_s;
  logic [6:0]           drop_inc_s;
  logic [DROP_W:0]      drop_sum_s;
  logic [PKT_W-1:0]     push_data_s;

  assign pop_s = pkt_valid && pkt_ready;

  // Round-robin search starting at ptr; a grant needs room after this cycle's pop.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = {PW{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_UNITS;
      if (!gnt_found_s && pend_q[idx]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = PW'(idx);
      end
    end
    gnt_s       = gnt_found_s && (!fifo_full_s || pop_s);
    push_data_s = make_pkt(code_q[gnt_idx_s], UNIT_W'(gnt_idx_s));
    if (gnt_s) ptr_d = (int'(gnt_idx_s) == NUM_UNITS - 1) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
    else       ptr_d = ptr_q;
  end

  // Slot update: a granted slot may be reloaded in the same cycle; a busy ungranted slot drops.
  always_comb begin
    logic granted, is_new;
    granted    = 1'b0;
    is_new     = 1'b0;
    drop_inc_s = 7'd0;
    pend_d     = pend_q;
    for (int j = 0; j < NUM_UNITS; j++) begin
      code_d[j] = code_q[j];
      granted   = gnt_s && (gnt_idx_s == PW'(j));
      is_new    = (event_in_array[2*j +: 2] != EVT_NONE);
      if (is_new && (!pend_q[j] || granted)) begin
        pend_d[j] = 1'b1;
        code_d[j] = event_in_array[2*j +: 2];
      end else if (granted) begin
        pend_d[j] = 1'b0;
      end else if (is_new) begin
        drop_inc_s = drop_inc_s + 7'd1;
      end else begin
        pend_d[j] = pend_q[j];
      end
    end
    drop_sum_s = {1'b0, drop_q} + (DROP_W+1)'(drop_inc_s);
    drop_d     = (drop_sum_s > (DROP_W+1)'(255)) ? 8'hFF : drop_sum_s[DROP_W-1:0];
  end

  // Slot, pointer and drop-counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= {NUM_UNITS{1'b0}};
      for (int j = 0; j < NUM_UNITS; j++) code_q[j] <= EVT_NONE;
      ptr_q  <= {PW{1'b0}};
      drop_q <= {DROP_W{1'b0}};
    end else begin
      pend_q <= pend_d;
      for (int j = 0; j < NUM_UNITS; j++) code_q[j] <= code_d[j];
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
    end
  end

  event_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (gnt_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .head_data  (pkt_data),
    .head_valid (pkt_valid),
    .full       (fifo_full_s),
    .level      (fifo_level)
  );

  assign drop_count = drop_q;
endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer with hand-computed packet sequences.
module tb_event_packetizer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] event_in_array;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] drop_count;
  logic [3:0] fifo_level;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_pkts;

  event_packetizer #(.NUM_UNITS(4), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .event_in_array (event_in_array),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    event_in_array = 8'h00;
    pkt_ready      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_data", {24'd0, pkt_data}, 32'h00);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);

    // 1: single event from unit 2
    pkt_ready = 1'b1;
    event_in_array = 8'b00_01_00_00;
    tick();
    event_in_array = 8'h00;
    chk("t1_valid_e0", {31'd0, pkt_valid}, 32'd0);
    tick();
    chk("t1_valid_e1", {31'd0, pkt_valid}, 32'd1);
    chk("t1_data", {24'd0, pkt_data}, 32'h42);
    tick();
    chk("t1_valid_after", {31'd0, pkt_valid}, 32'd0);
    chk("t1_drop", {24'd0, drop_count}, 32'd0);

    // 2: simultaneous events, ptr = 0
    do_reset();
    pkt_ready = 1'b1;
    event_in_array = 8'b01_11_10_01;
    tick();
    event_in_array = 8'h00;
    tick();
    chk("t2_p0", {23'd0, pkt_valid, pkt_data}, 32'h140);
    tick();
    chk("t2_p1", {23'd0, pkt_valid, pkt_data}, 32'h181);
    tick();
    chk("t2_p2", {23'd0, pkt_valid, pkt_data}, 32'h1C2);
    tick();
    chk("t2_p3", {23'd0, pkt_valid, pkt_data}, 32'h143);
    tick();
    chk("t2_empty", {31'd0, pkt_valid}, 32'd0);

    // 3: round robin resumes after unit 1
    do_reset();
    pkt_ready = 1'b1;
    event_in_array = 8'b00_00_01_00;
    tick();
    event_in_array = 8'b11_00_00_01;
    tick();
    event_in_array = 8'h00;
    chk("t3_p0", {23'd0, pkt_valid, pkt_data}, 32'h141);
    tick();
    chk("t3_p1", {23'd0, pkt_valid, pkt_data}, 32'h1C3);
    tick();
    chk("t3_p2", {23'd0, pkt_valid, pkt_data}, 32'h140);

    // 4: backpressure and overflow on unit 0
    do_reset();
    for (int k = 0; k < 12; k++) begin
      event_in_array = 8'b00_00_00_01;
      tick();
      event_in_array = 8'h00;
      if (k > 0) chk("t4_stable", {23'd0, pkt_valid, pkt_data}, 32'h140);
      tick();
    end
    chk("t4_level", {28'd0, fifo_level}, 32'd8);
    chk("t4_drop", {24'd0, drop_count}, 32'd3);
    chk("t4_data", {23'd0, pkt_valid, pkt_data}, 32'h140);
    pkt_ready = 1'b1;
    n_pkts = 0;
    for (int k = 0; k < 14; k++) begin
      if (pkt_valid) begin
        n_pkts++;
        chk("t4_drain_data", {24'd0, pkt_data}, 32'h40);
      end
      tick();
    end
    chk("t4_drained", n_pkts, 32'd9);

    // 5: slot re-armed in its grant cycle
    do_reset();
    pkt_ready = 1'b1;
    event_in_array = 8'b00_00_01_00;
    tick();
    event_in_array = 8'b00_00_10_00;
    tick();
    event_in_array = 8'h00;
    chk("t5_p0", {23'd0, pkt_valid, pkt_data}, 32'h141);
    tick();
    chk("t5_p1", {23'd0, pkt_valid, pkt_data}, 32'h181);
    tick();
    chk("t5_empty", {31'd0, pkt_valid}, 32'd0);
    chk("t5_drop", {24'd0, drop_count}, 32'd0);

    // 6a: asynchronous reset with 5 packets queued
    do_reset();
    event_in_array = 8'b01_11_10_01;
    tick();
    event_in_array = 8'h00;
    repeat (4) tick();
    event_in_array = 8'b00_01_00_00;
    tick();
    event_in_array = 8'h00;
    tick();
    chk("t6_level5", {28'd0, fifo_level}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, pkt_data}, 32'h00);
    chk("t6_rst_level", {28'd0, fifo_level}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_stale", {31'd0, pkt_valid}, 32'd0);
    end

    // 6b: drop counter saturation
    do_reset();
    event_in_array = 8'hFF;
    tick();
    tick();
    tick();
    chk("t6_drop_early", {24'd0, drop_count}, 32'd6);
    repeat (120) tick();
    chk("t6_drop_sat", {24'd0, drop_count}, 32'hFF);
    event_in_array = 8'h00;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
